// File: rtl/adder_ft_ctrl.sv
// adder_ft_ctrl
// -------------
// Sequencer and round-robin arbiter in front of the shared triple-modular-
// redundant adder (adder_ft). One requester is granted at a time; its
// operands are copied into three replica registers that drive the adder.
// The voted result is sampled one cycle later, then returned on a tagged
// response channel that holds until accepted.
//
// Optional feature macro: ADDER_FT_CTRL_RETRY_EN
//   defined   : on a voter disagreement the operation is re-executed, up to
//               MAX_RETRY times; rsp_err_o reports only a disagreement seen
//               on the last allowed attempt.
//   undefined : EXEC lasts exactly one cycle and rsp_err_o is the sampled
//               disagreement flag; MAX_RETRY has no effect.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake (ready is one-hot or 0)
//   req_a_i/req_b_i/req_cin_i  per-requester operands
//   add_a_o/add_b_o/add_cin_o  three registered operand replicas to adder
//   add_out_i/add_cout_i    voted sum and carry-out from adder
//   add_err_i               adder voter disagreement
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_id_o/rsp_sum_o/rsp_cout_o/rsp_err_o  response payload
//   err_cnt_o               saturating count of EXEC cycles with add_err_i
//
// Handshake semantics (both channels): a transfer happens in exactly the
// cycle where valid and ready are both high at the rising clock edge. A
// valid source does not need ready to assert valid; the payload of the
// response channel is held stable for as long as rsp_valid_o is high.
//
// FSM state is held in r_state (type state_t) for observation by checkers.

module adder_ft_ctrl #(
  parameter int BIT       = 8,
  parameter int NREQ      = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NREQ-1:0]               req_valid_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic [NREQ-1:0][BIT-1:0]      req_a_i,
  input  logic [NREQ-1:0][BIT-1:0]      req_b_i,
  input  logic [NREQ-1:0]               req_cin_i,
  output logic [2:0][BIT-1:0]           add_a_o,
  output logic [2:0][BIT-1:0]           add_b_o,
  output logic [2:0]                    add_cin_o,
  input  logic [BIT-1:0]                add_out_i,
  input  logic                          add_cout_i,
  input  logic                          add_err_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NREQ)-1:0]       rsp_id_o,
  output logic [BIT-1:0]                rsp_sum_o,
  output logic                          rsp_cout_o,
  output logic                          rsp_err_o,
  output logic [7:0]                    err_cnt_o
);

  localparam int IW = $clog2(NREQ);

  // Parameter sanity checks at elaboration.
  if (NREQ < 2) begin : g_bad_nreq
    $error("adder_ft_ctrl: NREQ must be at least 2");
  end
  if (MAX_RETRY < 1) begin : g_bad_retry
    $error("adder_ft_ctrl: MAX_RETRY must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_gnt;
  logic [2:0][BIT-1:0] r_add_a;
  logic [2:0][BIT-1:0] r_add_b;
  logic [2:0]          r_add_cin;
  logic [BIT-1:0]      r_rsp_sum;
  logic                r_rsp_cout;
  logic                r_rsp_err;
  logic [7:0]          r_err_cnt;

  logic [IW-1:0]       w_scan;
  logic [IW-1:0]       w_gnt_idx;
  logic                w_gnt_vld;
  logic                w_accept;
  logic                w_retry_ok;
  logic                w_do_retry;

  // Round-robin search: start one past the last served requester and walk
  // upward with wrap. The explicit wrap keeps this correct when NREQ is not
  // a power of two.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = r_last;
    for (int k = 0; k < NREQ; k++) begin
      if (w_scan == IW'(NREQ - 1)) w_scan = '0;
      else                         w_scan = w_scan + IW'(1);
      if (!w_gnt_vld && req_valid_i[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

`ifdef ADDER_FT_CTRL_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic [RW-1:0] r_retry;

  assign w_retry_ok = (r_retry < RW'(MAX_RETRY));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_retry <= '0;
    end else if (w_accept) begin
      r_retry <= '0;
    end else if (w_do_retry) begin
      r_retry <= r_retry + RW'(1);
    end
  end
`else
  assign w_retry_ok = 1'b0;
`endif

  assign w_do_retry = (r_state == ST_EXEC) && add_err_i && w_retry_ok;

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!w_do_retry) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Grant is combinational in IDLE; held low while reset is asserted so the
  // reset value of req_ready_o is zero regardless of request inputs.
  always_comb begin
    req_ready_o = '0;
    if (!rst_i && (r_state == ST_IDLE) && w_gnt_vld) begin
      req_ready_o[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_last     <= IW'(NREQ - 1);
      r_gnt      <= '0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_add_cin  <= '0;
      r_rsp_sum  <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_add_a   <= {3{req_a_i[w_gnt_idx]}};
        r_add_b   <= {3{req_b_i[w_gnt_idx]}};
        r_add_cin <= {3{req_cin_i[w_gnt_idx]}};
        r_gnt     <= w_gnt_idx;
      end

      if ((r_state == ST_EXEC) && add_err_i && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      // Final attempt of this transaction: latch the voted result.
      if ((r_state == ST_EXEC) && !w_do_retry) begin
        r_rsp_sum  <= add_out_i;
        r_rsp_cout <= add_cout_i;
        r_rsp_err  <= add_err_i;
      end

      if ((r_state == ST_RESP) && rsp_ready_i) begin
        r_last <= r_gnt;
      end
    end
  end

  assign add_a_o     = r_add_a;
  assign add_b_o     = r_add_b;
  assign add_cin_o   = r_add_cin;
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_id_o    = r_gnt;
  assign rsp_sum_o   = r_rsp_sum;
  assign rsp_cout_o  = r_rsp_cout;
  assign rsp_err_o   = r_rsp_err;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: doc/adder_ft_ctrl.md
# adder_ft_ctrl

Sequencer and arbiter for the shared triple-modular-redundant adder (`adder_ft`). It accepts add requests from `NREQ` requesters and grants one at a time in round-robin order. It drives the adder's three replicated operand copies from registers, samples the voted result together with the voter-disagreement flag, and re-executes on disagreement. Results return on a single tagged response channel with backpressure.

## Interface
- `BIT`, 8, operand/result width
- `NREQ`, 2, number of requesters (≥2)
- `MAX_RETRY`, 2, maximum re-executions after a voter disagreement (≥1; used only with the retry feature)

- `clk_i` in 1 — single clock, all state on rising edge
- `rst_i` in 1 — reset, asynchronous, active-high
- `req_valid_i` in `NREQ` — per-requester request valid
- `req_ready_o` out `NREQ` — per-requester accept; at most one bit high
- `req_a_i` in `NREQ`×`BIT` — operand A per requester
- `req_b_i` in `NREQ`×`BIT` — operand B per requester
- `req_cin_i` in `NREQ` — carry-in per requester
- `add_a_o` out 3×`BIT` — replicated operand A to adder
- `add_b_o` out 3×`BIT` — replicated operand B to adder
- `add_cin_o` out 3 — replicated carry-in to adder
- `add_out_i` in `BIT` — voted sum from adder
- `add_cout_i` in 1 — voted carry-out from adder
- `add_err_i` in 1 — adder voter disagreement (any replica mismatch)
- `rsp_valid_o` out 1 — response valid
- `rsp_ready_i` in 1 — response accept
- `rsp_id_o` out `$clog2(NREQ)` — index of the served requester
- `rsp_sum_o` out `BIT` — sum
- `rsp_cout_o` out 1 — carry-out
- `rsp_err_o` out 1 — final attempt saw a disagreement
- `err_cnt_o` out 8 — saturating count of EXEC cycles with `add_err_i`=1

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid_i` bit is high, grant the first valid requester searching upward (with wrap) from `last+1`.
  - Assert `req_ready_o[g]` combinationally in the same cycle.
  - Load all three operand replica registers with that requester's A, B and cin; store `g`; clear the retry count; go to EXEC.
- EXEC: the adder is combinational, so sample `add_out_i`, `add_cout_i` and `add_err_i` at the end of the cycle.
  - If `add_err_i`=1, increment `err_cnt_o` (saturates at 255).
  - If `add_err_i`=1 and retries remain, increment the retry count and stay in EXEC with the same operands.
  - Otherwise capture sum, cout and err into the response registers and go to RESP.
- RESP:
  - Hold `rsp_valid_o`=1 with all `rsp_*` outputs stable.
  - On `rsp_ready_i`=1, set `last`←`g` and go to IDLE.
- `req_ready_o` is all-zero outside IDLE. No request is accepted while a response is pending.
- Operand registers hold their last value after a transaction. They are never driven from unregistered request inputs.
- Reset values:
  - all `add_*_o`, `rsp_*` outputs and `err_cnt_o` are 0; `req_ready_o` is 0
  - `last`=`NREQ-1`, so requester 0 has priority first after reset

## Timing
- Accept→`rsp_valid_o`: 2 cycles without retries. Each retry adds 1 cycle.
- Minimum throughput: 1 transaction per 3 cycles with `rsp_ready_i` held at 1.
- Simultaneous valid requests: round-robin, with no requester served twice while another is waiting.
- A requester that drops `req_valid_i` before being granted is simply not served.
- The response handshake is completed only by `rsp_valid_o`&`rsp_ready_i`.
- `rst_i` asserted in any state: immediate return to IDLE and reset values. Any in-flight transaction is lost and produces no response.

## Configuration
- `ADDER_FT_CTRL_RETRY_EN` defined:
  - up to `MAX_RETRY` re-executions per transaction
  - `rsp_err_o`=1 only if the last allowed attempt still disagreed
  - worst-case latency is `2+MAX_RETRY` cycles
- Not defined:
  - EXEC always lasts one cycle
  - `rsp_err_o` equals `add_err_i` sampled in that cycle
  - `MAX_RETRY` is ignored
- `err_cnt_o` behaves identically in both builds.

## Test plan
- After reset, req0 requests A=0x25, B=0x45, cin=0; adder model is fault-free. Required: `req_ready_o`=01 in the same cycle; `add_a_o` shows three copies of 0x25 next cycle; `rsp_valid_o` 2 cycles after accept with sum=0x6A, cout=0, id=0, err=0.
- req0 and req1 both valid continuously; req1 requests 0xFF+0x01, cin=1. Required: grants alternate req0, req1, req0, …; req1's response is sum=0x01, cout=1.
- Retry enabled; `add_err_i` injected for one EXEC cycle. Required: one extra EXEC cycle; response err=0 with the correct sum; `err_cnt_o`=1.
- Retry enabled with `MAX_RETRY`=2; `add_err_i` stuck at 1. Required: 3 EXEC cycles; response err=1; `err_cnt_o`=3. Retry disabled, same stimulus: 1 EXEC cycle, err=1, `err_cnt_o`=1.
- `rsp_ready_i` held at 0 for 5 cycles while req1 is valid. Required: `rsp_*` outputs stable; `req_ready_o`=0 throughout; req1 granted in the first IDLE cycle after the handshake.
- `rst_i` pulsed during EXEC. Required: outputs return to reset values asynchronously; no response is issued; req0 is granted first afterwards.
